// File: rtl/pipe_core_pkg.sv
// Shared types and instruction-field helpers for the parametrised 4-stage core.
// Field helpers take the word zero-extended to 64 bits so every width configuration can use them.
package pipe_core_pkg;

    typedef enum logic [2:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpLoad, OpStore, OpAddi, OpHalt
    } opcode_e;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;
    localparam logic [1:0] StHalted = 2'd3;

    function automatic logic [31:0] get_field(input logic [63:0] word, input int unsigned lsb,
                                              input int unsigned width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return 32'((word >> lsb) & mask);
    endfunction

    function automatic logic [31:0] instr_op(input logic [63:0] w, input int unsigned rw,
                                             input int unsigned dw);
        return get_field(w, dw + 3 * rw, 3);
    endfunction

    function automatic logic [31:0] instr_rd(input logic [63:0] w, input int unsigned rw,
                                             input int unsigned dw);
        return get_field(w, dw + 2 * rw, rw);
    endfunction

    function automatic logic [31:0] instr_rs1(input logic [63:0] w, input int unsigned rw,
                                              input int unsigned dw);
        return get_field(w, dw + rw, rw);
    endfunction

    function automatic logic [31:0] instr_rs2(input logic [63:0] w, input int unsigned rw,
                                              input int unsigned dw);
        return get_field(w, dw, rw);
    endfunction

    function automatic logic [31:0] instr_imm(input logic [63:0] w, input int unsigned dw);
        return get_field(w, 0, dw);
    endfunction

    function automatic logic op_writes_rd(input opcode_e op);
        return !(op inside {OpStore, OpHalt});
    endfunction

endpackage

// File: rtl/pipe_core_if.sv
// Control, program-load and debug bundle of the core.
// The master side drives run control and the instruction-memory load port.
interface pipe_core_if #(
    parameter int DATA_W     = 8,
    parameter int NREGS      = 16,
    parameter int IMEM_DEPTH = 16
);
    localparam int RW   = $clog2(NREGS);
    localparam int IA_W = $clog2(IMEM_DEPTH);
    localparam int IW   = 3 + 3 * RW + DATA_W;

    logic              start;
    logic              imem_we;
    logic [IA_W-1:0]   imem_addr;
    logic [IW-1:0]     imem_wdata;
    logic [RW-1:0]     dbg_raddr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              busy;
    logic              halted;
    logic [31:0]       retired_count;

    modport master (
        output start, imem_we, imem_addr, imem_wdata, dbg_raddr,
        input  dbg_rdata, busy, halted, retired_count
    );

    modport slave (
        input  start, imem_we, imem_addr, imem_wdata, dbg_raddr,
        output dbg_rdata, busy, halted, retired_count
    );

endinterface

// File: rtl/pipe_core_regfile.sv
// Register file: one write port, two write-first read ports for ID and a plain debug port.
// r0 is never written and always reads zero.
module pipe_core_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [$clog2(NREGS)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(NREGS)-1:0] i_raddr_a,
    input  logic [$clog2(NREGS)-1:0] i_raddr_b,
    input  logic [$clog2(NREGS)-1:0] i_raddr_dbg,
    output logic [DATA_W-1:0]        o_rdata_a,
    output logic [DATA_W-1:0]        o_rdata_b,
    output logic [DATA_W-1:0]        o_rdata_dbg
);
    logic [DATA_W-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (i_we && i_waddr != '0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        if (i_we && i_waddr == i_raddr_a) o_rdata_a = i_wdata;
        if (i_raddr_a == '0) o_rdata_a = '0;
    end

    always_comb begin
        o_rdata_b = r_regs[i_raddr_b];
        if (i_we && i_waddr == i_raddr_b) o_rdata_b = i_wdata;
        if (i_raddr_b == '0) o_rdata_b = '0;
    end

    assign o_rdata_dbg = (i_raddr_dbg == '0) ? '0 : r_regs[i_raddr_dbg];

endmodule

// File: rtl/pipe_core_param.sv
// Parametrised IF/ID/EX/WB in-order core with forwarding, run control and retire counter.
// HALT in ID stops fetch; the core reports halted once HALT leaves WB.
module pipe_core_param
    import pipe_core_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NREGS      = 16,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 256
) (
    input logic        clk,
    input logic        rst_n,
    pipe_core_if.slave bus
);
    localparam int RW   = $clog2(NREGS);
    localparam int IA_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);
    localparam int IW   = 3 + 3 * RW + DATA_W;

    logic [1:0]        r_state, w_state_d;
    logic [IA_W-1:0]   r_pc;
    logic [31:0]       r_retired;
    logic [IW-1:0]     r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];
    logic [DATA_W-1:0] r_dmem_rdata;

    logic              r_ifid_valid;
    logic [IW-1:0]     r_ifid_instr;

    logic              r_idex_valid;
    opcode_e           r_idex_op;
    logic [RW-1:0]     r_idex_rd, r_idex_rs1, r_idex_rs2;
    logic [DATA_W-1:0] r_idex_imm, r_idex_a, r_idex_b;

    logic              r_exwb_valid;
    opcode_e           r_exwb_op;
    logic [RW-1:0]     r_exwb_rd;
    logic [DATA_W-1:0] r_exwb_res;

    logic [63:0]       w_ifid_ext;
    opcode_e           w_id_op;
    logic [RW-1:0]     w_id_rd, w_id_rs1, w_id_rs2;
    logic [DATA_W-1:0] w_id_imm, w_id_a, w_id_b;
    logic              w_id_halt, w_fetch, w_start_ok;
    logic              w_wb_we, w_retire;
    logic [DATA_W-1:0] w_wb_data, w_ex_a, w_ex_b, w_ex_sum, w_ex_res, w_dbg_rdata;
    logic [DA_W-1:0]   w_ex_addr;

    assign w_ifid_ext = 64'(r_ifid_instr);
    assign w_id_op    = opcode_e'(3'(instr_op(w_ifid_ext, RW, DATA_W)));
    assign w_id_rd    = RW'(instr_rd(w_ifid_ext, RW, DATA_W));
    assign w_id_rs1   = RW'(instr_rs1(w_ifid_ext, RW, DATA_W));
    assign w_id_rs2   = RW'(instr_rs2(w_ifid_ext, RW, DATA_W));
    assign w_id_imm   = DATA_W'(instr_imm(w_ifid_ext, DATA_W));

    assign w_id_halt  = r_ifid_valid && (w_id_op == OpHalt);
    assign w_fetch    = (r_state == StRun) && !w_id_halt;
    assign w_start_ok = bus.start && (r_state == StIdle || r_state == StHalted);

    assign w_wb_we   = r_exwb_valid && op_writes_rd(r_exwb_op);
    assign w_wb_data = (r_exwb_op == OpLoad) ? r_dmem_rdata : r_exwb_res;
    assign w_retire  = r_exwb_valid && (r_exwb_op != OpHalt);

    // One-deep forward from WB; older results arrive via the regfile's write-first read in ID.
    assign w_ex_a = (w_wb_we && r_exwb_rd != '0 && r_exwb_rd == r_idex_rs1) ? w_wb_data : r_idex_a;
    assign w_ex_b = (w_wb_we && r_exwb_rd != '0 && r_exwb_rd == r_idex_rs2) ? w_wb_data : r_idex_b;
    assign w_ex_sum  = w_ex_a + r_idex_imm;
    assign w_ex_addr = DA_W'(w_ex_sum);

    always_comb begin
        w_ex_res = '0;
        case (r_idex_op)
            OpAdd:                   w_ex_res = w_ex_a + w_ex_b;
            OpSub:                   w_ex_res = w_ex_a - w_ex_b;
            OpAnd:                   w_ex_res = w_ex_a & w_ex_b;
            OpOr:                    w_ex_res = w_ex_a | w_ex_b;
            OpAddi, OpLoad, OpStore: w_ex_res = w_ex_sum;
            default:                 w_ex_res = '0;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle, StHalted: if (bus.start) w_state_d = StRun;
            StRun:            if (w_id_halt) w_state_d = StDrain;
            StDrain:          if (r_exwb_valid && r_exwb_op == OpHalt) w_state_d = StHalted;
            default:          w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_pc         <= '0;
            r_ifid_valid <= 1'b0;
            r_idex_valid <= 1'b0;
            r_exwb_valid <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_start_ok) r_pc <= '0;
            else if (w_fetch) r_pc <= r_pc + IA_W'(1);
            r_ifid_valid <= w_fetch;
            r_idex_valid <= r_ifid_valid;
            r_exwb_valid <= r_idex_valid;
            if (w_retire && r_retired != '1) r_retired <= r_retired + 32'd1;
        end
    end

    // Payload registers carry no reset; the valid bits above qualify them.
    always_ff @(posedge clk) begin
        r_ifid_instr <= r_imem[r_pc];
        r_idex_op    <= w_id_op;
        r_idex_rd    <= w_id_rd;
        r_idex_rs1   <= w_id_rs1;
        r_idex_rs2   <= w_id_rs2;
        r_idex_imm   <= w_id_imm;
        r_idex_a     <= w_id_a;
        r_idex_b     <= w_id_b;
        r_exwb_op    <= r_idex_op;
        r_exwb_rd    <= r_idex_rd;
        r_exwb_res   <= w_ex_res;
        r_dmem_rdata <= r_dmem[w_ex_addr];
        if (rst_n && r_idex_valid && r_idex_op == OpStore) r_dmem[w_ex_addr] <= w_ex_b;
        if (bus.imem_we) r_imem[bus.imem_addr] <= bus.imem_wdata;
    end

    pipe_core_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_we        (w_wb_we),
        .i_waddr     (r_exwb_rd),
        .i_wdata     (w_wb_data),
        .i_raddr_a   (w_id_rs1),
        .i_raddr_b   (w_id_rs2),
        .i_raddr_dbg (bus.dbg_raddr),
        .o_rdata_a   (w_id_a),
        .o_rdata_b   (w_id_b),
        .o_rdata_dbg (w_dbg_rdata)
    );

    assign bus.dbg_rdata     = w_dbg_rdata;
    assign bus.busy          = (r_state == StRun) || (r_state == StDrain);
    assign bus.halted        = (r_state == StHalted);
    assign bus.retired_count = r_retired;

endmodule

// File: tb/tb_pipe_core_param.sv
// Self-checking bench: table of single-op programs, directed multi-cycle sequences and
// random straight-line programs checked against a sequential ISA model.
module tb_pipe_core_param;
    import pipe_core_pkg::*;

    localparam int DATA_W = 8;
    localparam int NREGS = 16;
    localparam int IMEM_DEPTH = 16;
    localparam int DMEM_DEPTH = 256;
    localparam int IW = 3 + 3 * 4 + DATA_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    pipe_core_if #(.DATA_W(DATA_W), .NREGS(NREGS), .IMEM_DEPTH(IMEM_DEPTH)) bus ();

    pipe_core_param #(
        .DATA_W(DATA_W), .NREGS(NREGS), .IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] imm;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];
    logic [IW-1:0] pmem [16];
    logic [7:0] m_reg [16];
    logic [7:0] m_dmem [256];
    int stored_q[$];

    function automatic logic [IW-1:0] enc(input logic [2:0] op, input int rd, input int rs1,
                                          input int rs2, input logic [7:0] imm);
        return {op, 4'(rd), 4'(rs1), 4'(rs2), imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input int idx, input logic [7:0] exp, input string name);
        bus.dbg_raddr = 4'(idx);
        @(negedge clk);
        check(name, 32'(bus.dbg_rdata), 32'(exp));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.imem_we = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic write_imem(input int addr, input logic [IW-1:0] w);
        bus.imem_we = 1'b1;
        bus.imem_addr = 4'(addr);
        bus.imem_wdata = w;
        @(posedge clk);
        #1 bus.imem_we = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) pmem[i] = enc(OpHalt, 0, 0, 0, 8'h00);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) write_imem(i, pmem[i]);
    endtask

    // Pulses start, returns edges from the start edge until halted (-1 if never).
    task automatic run_prog(output int lat);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (bus.halted) begin
                lat = c;
                break;
            end
        end
    endtask

    // Builds a random program while executing it on the model, one instruction at a time.
    task automatic gen_random(output int len);
        int op, rd, rs1, rs2, addr;
        logic [7:0] imm, a, b, res, s;
        bit wr;
        len = $urandom_range(4, 15);
        clear_prog();
        for (int i = 0; i < len; i++) begin
            op = $urandom_range(0, 6);
            rd = $urandom_range(0, 5);
            rs1 = $urandom_range(0, 5);
            rs2 = $urandom_range(0, 5);
            imm = 8'($urandom);
            a = m_reg[rs1];
            b = m_reg[rs2];
            res = 8'h00;
            wr = 1'b1;
            if (op == 4 && stored_q.size() == 0) op = 6;
            case (op)
                0: res = a + b;
                1: res = a - b;
                2: res = a & b;
                3: res = a | b;
                4: begin
                    addr = stored_q[$urandom_range(0, stored_q.size() - 1)];
                    imm = 8'(addr) - a;
                    res = m_dmem[addr];
                end
                5: begin
                    s = a + imm;
                    addr = int'(s);
                    m_dmem[addr] = b;
                    stored_q.push_back(addr);
                    wr = 1'b0;
                end
                default: res = a + imm;
            endcase
            if (wr && rd != 0) m_reg[rd] = res;
            pmem[i] = enc(3'(op), rd, rs1, rs2, imm);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat, len;
        bus.start = 1'b0;
        bus.imem_we = 1'b0;
        bus.imem_addr = '0;
        bus.imem_wdata = '0;
        bus.dbg_raddr = '0;

        vecs[0] = '{OpAdd,  8'h12, 8'h34, 8'h5A, 8'h46};
        vecs[1] = '{OpAdd,  8'hF0, 8'h20, 8'h5A, 8'h10};
        vecs[2] = '{OpSub,  8'h10, 8'h20, 8'h5A, 8'hF0};
        vecs[3] = '{OpSub,  8'h55, 8'h55, 8'h5A, 8'h00};
        vecs[4] = '{OpAnd,  8'hF0, 8'h3C, 8'h5A, 8'h30};
        vecs[5] = '{OpOr,   8'hA0, 8'h0C, 8'h5A, 8'hAC};
        vecs[6] = '{OpAddi, 8'h7F, 8'h33, 8'h81, 8'h00};
        vecs[7] = '{OpAddi, 8'h01, 8'h33, 8'h10, 8'h11};

        do_reset();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset halted", 32'(bus.halted), 32'd0);
        check("reset retired", bus.retired_count, 32'd0);
        chk_reg(5, 8'h00, "reset r5");

        for (int i = 0; i < 8; i++) begin
            do_reset();
            clear_prog();
            pmem[0] = enc(OpAddi, 1, 0, 0, vecs[i].a);
            pmem[1] = enc(OpAddi, 2, 0, 0, vecs[i].b);
            pmem[2] = enc(vecs[i].op, 3, 1, 2, vecs[i].imm);
            load_prog();
            run_prog(lat);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd7);
            check($sformatf("vec%0d retired", i), bus.retired_count, 32'd3);
            chk_reg(3, vecs[i].exp, $sformatf("vec%0d r3", i));
        end

        // Forwarding chain
        do_reset();
        clear_prog();
        pmem[0] = enc(OpAddi, 1, 0, 0, 8'd20);
        pmem[1] = enc(OpAddi, 2, 0, 0, 8'd5);
        pmem[2] = enc(OpAdd, 3, 1, 2, 8'd0);
        pmem[3] = enc(OpSub, 4, 3, 1, 8'd0);
        load_prog();
        run_prog(lat);
        check("fwd latency", 32'(lat), 32'd8);
        check("fwd retired", bus.retired_count, 32'd4);
        chk_reg(1, 8'd20, "fwd r1");
        chk_reg(2, 8'd5, "fwd r2");
        chk_reg(3, 8'd25, "fwd r3");
        chk_reg(4, 8'd5, "fwd r4");

        // Store then load, then use of the loaded value
        do_reset();
        clear_prog();
        pmem[0] = enc(OpAddi, 1, 0, 0, 8'hAA);
        pmem[1] = enc(OpStore, 0, 0, 1, 8'd10);
        pmem[2] = enc(OpLoad, 5, 0, 0, 8'd10);
        pmem[3] = enc(OpAdd, 6, 5, 5, 8'd0);
        load_prog();
        run_prog(lat);
        check("ldst latency", 32'(lat), 32'd8);
        check("ldst retired", bus.retired_count, 32'd4);
        chk_reg(5, 8'hAA, "ldst r5");
        chk_reg(6, 8'h54, "ldst r6");

        // r0 stays zero, address wraps to 0x00
        do_reset();
        clear_prog();
        pmem[0] = enc(OpAddi, 3, 0, 0, 8'h3C);
        pmem[1] = enc(OpStore, 0, 0, 3, 8'h00);
        pmem[2] = enc(OpAddi, 0, 0, 0, 8'd7);
        pmem[3] = enc(OpAddi, 1, 0, 0, 8'hFF);
        pmem[4] = enc(OpAddi, 1, 1, 0, 8'd2);
        pmem[5] = enc(OpLoad, 2, 1, 0, 8'hFF);
        load_prog();
        run_prog(lat);
        check("wrap latency", 32'(lat), 32'd10);
        check("wrap retired", bus.retired_count, 32'd6);
        chk_reg(0, 8'h00, "wrap r0");
        chk_reg(1, 8'h01, "wrap r1");
        chk_reg(2, 8'h3C, "wrap r2");

        // HALT squashes the younger instruction; restart keeps registers
        do_reset();
        clear_prog();
        pmem[0] = enc(OpAddi, 1, 1, 0, 8'd1);
        pmem[2] = enc(OpAddi, 7, 0, 0, 8'd9);
        load_prog();
        run_prog(lat);
        check("squash latency", 32'(lat), 32'd5);
        check("squash busy", 32'(bus.busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("squash halted hold", 32'(bus.halted), 32'd1);
        check("squash retired", bus.retired_count, 32'd1);
        chk_reg(7, 8'h00, "squash r7");
        chk_reg(1, 8'h01, "squash r1");
        run_prog(lat);
        check("rerun latency", 32'(lat), 32'd5);
        check("rerun retired", bus.retired_count, 32'd2);
        chk_reg(1, 8'h02, "rerun r1");
        chk_reg(7, 8'h00, "rerun r7");

        // Reset while running, with start asserted in the same cycle
        do_reset();
        for (int i = 0; i < 16; i++) pmem[i] = enc(OpAddi, 1, 1, 0, 8'd1);
        load_prog();
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midrun busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.start = 1'b0;
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst halted", 32'(bus.halted), 32'd0);
        check("midrst retired", bus.retired_count, 32'd0);
        chk_reg(1, 8'h00, "midrst r1");
        write_imem(3, enc(OpHalt, 0, 0, 0, 8'h00));
        run_prog(lat);
        check("postrst latency", 32'(lat), 32'd7);
        check("postrst retired", bus.retired_count, 32'd3);
        chk_reg(1, 8'd3, "postrst r1");

        // PC wrap with live imem rewrites and an ignored start
        do_reset();
        for (int i = 0; i < 15; i++) pmem[i] = enc(OpAddi, 1, 1, 0, 8'd1);
        pmem[15] = enc(OpHalt, 0, 0, 0, 8'h00);
        load_prog();
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.imem_we = 1'b0;
            if (bus.halted) begin
                lat = c;
                break;
            end
            if (c == 2) begin
                bus.imem_we = 1'b1;
                bus.imem_addr = 4'd2;
                bus.imem_wdata = enc(OpAddi, 3, 3, 0, 8'd1);
            end
            if (c == 5) bus.start = 1'b1;
            if (c == 8) begin
                bus.imem_we = 1'b1;
                bus.imem_addr = 4'd15;
                bus.imem_wdata = enc(OpAddi, 2, 2, 0, 8'd5);
            end
            if (c == 9) begin
                bus.imem_we = 1'b1;
                bus.imem_addr = 4'd3;
                bus.imem_wdata = enc(OpHalt, 0, 0, 0, 8'h00);
            end
        end
        bus.start = 1'b0;
        bus.imem_we = 1'b0;
        check("pcwrap latency", 32'(lat), 32'd23);
        check("pcwrap retired", bus.retired_count, 32'd19);
        chk_reg(1, 8'd17, "pcwrap r1");
        chk_reg(2, 8'd5, "pcwrap r2");
        chk_reg(3, 8'd1, "pcwrap r3");

        // Random programs against the ISA model
        for (int t = 0; t < 20; t++) begin
            do_reset();
            for (int r = 0; r < 16; r++) m_reg[r] = 8'h00;
            gen_random(len);
            load_prog();
            run_prog(lat);
            check($sformatf("rnd%0d latency", t), 32'(lat), 32'(4 + len));
            check($sformatf("rnd%0d retired", t), bus.retired_count, 32'(len));
            for (int r = 0; r < 16; r++) chk_reg(r, m_reg[r], $sformatf("rnd%0d r%0d", t, r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_core_param.md
Name: pipe_core_param

Overview:
- Parametrised 4-stage in-order core: IF, ID, EX, WB.
- Successor of the fixed 8-bit ADD/SUB/LOAD pipeline; that pipeline has no hazard handling, no stores and no run control.
- This block adds:
  - generic data width and register, instruction and data depths;
  - an 8-opcode ISA with STORE, ADDI and HALT;
  - operand forwarding;
  - a start/halt controller;
  - instruction-memory load port, debug register read and retire counter.

Parameters:
- DATA_W, 8: datapath, register and immediate width.
- NREGS, 16: register count; power of 2; RW = clog2(NREGS).
- IMEM_DEPTH, 16: instruction words; power of 2; IA_W = clog2(IMEM_DEPTH).
- DMEM_DEPTH, 256: data words; power of 2; DA_W = clog2(DMEM_DEPTH).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins execution at pc 0.
- imem_we  in  1  instruction-memory write enable.
- imem_addr  in  IA_W  instruction-memory write address.
- imem_wdata  in  IW  instruction word; IW = 3+3*RW+DATA_W.
- dbg_raddr  in  RW  debug register index.
- dbg_rdata  out  DATA_W  combinational register read; r0 reads 0.
- busy  out  1  high in RUN and DRAIN.
- halted  out  1  high in HALTED.
- retired_count  out  32  instructions retired, HALT excluded.

Behaviour:
- Reset (rst_n low at edge): state IDLE, pc=0, all stage valid bits 0, all registers 0, busy=0, halted=0, retired_count=0. Data and instruction memories are not cleared. Reset overrides start and in-flight instructions.
- Instruction format, MSB to LSB: opcode[3], rd[RW], rs1[RW], rs2[RW], imm[DATA_W].
- Opcodes:
  - 0 ADD: rd=rs1+rs2.
  - 1 SUB: rd=rs1-rs2.
  - 2 AND.
  - 3 OR.
  - 4 LOAD: rd=dmem[rs1+imm].
  - 5 STORE: dmem[rs1+imm]=rs2; no register write.
  - 6 ADDI: rd=rs1+imm.
  - 7 HALT.
- Arithmetic is modulo 2^DATA_W. Data address = low DA_W bits of (rs1+imm), so addresses wrap.
- r0 always reads 0; writes to r0 are dropped.
- States:
  - IDLE: start -> RUN.
  - RUN: HALT decoded in ID -> DRAIN.
  - DRAIN: HALT leaves WB -> HALTED.
  - HALTED: start -> RUN, pc=0, registers preserved.
  - start in RUN or DRAIN is ignored.
- Timing: start sampled at edge T. imem[0] is in IF_ID at T+1, ID_EX at T+2, EX_WB at T+3, and writes the register file at T+4. Throughput is 1 instruction/cycle with no stalls.
- HALT:
  - When HALT sits in ID, the next edge freezes pc and loads a bubble into IF_ID; younger instructions never execute.
  - HALT at index k puts halted high from T+4+k.
- PC increments by 1 per fetch in RUN and wraps modulo IMEM_DEPTH.
- Operand read in ID uses write-first bypass: a same-cycle WB write to the source register supplies the new value.
- EX forwarding: if EX_WB is valid and writes rd, rd≠0, and rd equals the EX source, use the EX_WB result. This covers back-to-back dependences including LOAD.
- Data memory timing:
  - STORE writes at the edge ending its EX.
  - LOAD reads synchronously at the edge ending its EX; data is valid in WB.
  - A LOAD immediately after a STORE to the same address returns the stored value.
- retired_count increments by 1 when a valid non-HALT instruction is in WB. It saturates at all-ones.
- imem writes are accepted in any state and take effect at the edge. A fetch of the same address in that cycle returns the old word.

Decomposition:
- Package pipe_core_pkg: opcode enum (3-bit), state enum (IDLE/RUN/DRAIN/HALTED), parametrised instruction field-extraction functions.
- Sub-module pipe_core_regfile holds NREGS×DATA_W storage with:
  - reset clear;
  - r0 forced to zero;
  - 1 write port;
  - 2 write-first read ports for ID, plus the debug read port.
- The core contains the pipeline registers, forwarding, FSM, memories and counter.

Test Plan:
- Forwarding: program ADDI r1,r0,20; ADDI r2,r0,5; ADD r3,r1,r2; SUB r4,r3,r1; HALT. Required: r1=20, r2=5, r3=25, r4=5, halted at T+8, retired_count=4.
- Store/load: ADDI r1,r0,0xAA; STORE r1 -> [r0+10]; LOAD r5,[r0+10]; ADD r6,r5,r5; HALT. Required: r5=0xAA, r6=0x54 (wrap), retired_count=4.
- r0 and wrap: ADDI r0,r0,7; ADDI r1,r0,0xFF; ADDI r1,r1,2; LOAD r2 with rs1=r1, imm 0xFF. Required: r0=0, r1=1, address 0x00 read.
- Halt squash: HALT at index 1, ADDI r7,r0,9 at index 2. Required: r7=0, busy falls, halted=1, pc frozen. A new start reruns from pc 0 with registers kept.
- Reset mid-run: drop rst_n while busy. Required next cycle: busy=0, halted=0, retired_count=0, all registers 0. A subsequent start reruns correctly.
- PC wrap: fill all 16 words with ADDI r1,r1,1 except word 15 = HALT, then reload word 15 while running. Required: pc wraps, and only the new word 15 content affects later fetches.
